frame_uart_tx: RTL
==================

# frame_uart_tx

Serializer that consumes the 14-byte response frame produced by the request-indexed memory stage (MARK, m1b1..m3b4, CRC8) and transmits it on an asynchronous UART line: 8N1, LSB first. It latches the whole frame on a start strobe and sends it as one uninterrupted burst. It sits directly downstream of the memory stage and drives the telemetry line driver.

## Interface
- CLK_DIV, 16: clk cycles per serial bit; legal range 2..65535.
- GAP_BITS, 0: extra idle-high bit times inserted after each byte's stop bit, except after the last byte; legal range 0..15.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iStart  in  1  single-cycle high strobe: latch the frame bytes and begin transmission.
- iMARK, im1b1, im1b2, im1b3, im1b4, im2b1, im2b2, im2b3, im2b4, im3b1, im3b2, im3b3, im3b4, iCRC8  in  8 each  frame bytes, in transmit order.
- oTX  out  1  serial line; idle high.
- oBusy  out  1  high while a frame is in progress.
- oDone  out  1  one-cycle high pulse when the final stop bit completes.
- oByteIdx  out  4  index 0..13 of the byte currently on the line; 0 when idle.

## Operation
- Frame buffer: 14 x 8-bit registers, loaded only when iStart=1 and state=IDLE. Inputs may change freely after the load cycle.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: on iStart, go to START with byte index 0.
  - START: oTX=0 for one bit time, then go to DATA.
  - DATA: 8 bit times, byte[idx] bit 0 first, then go to STOP.
  - STOP: oTX=1 for one bit time. Then:
    - if idx=13: go to IDLE and pulse oDone;
    - else if GAP_BITS>0: go to GAP;
    - else: idx+1 and go to START.
  - GAP: oTX=1 for GAP_BITS bit times, then idx+1 and go to START.
- Bit timer: counts 0..CLK_DIV-1; the bit boundary is the wrap to 0. The timer is cleared on entry to START from IDLE.
- Bit counter: 3 bits. Byte index: 4 bits, never exceeds 13.
- iStart while oBusy=1 is ignored. The buffer and the in-flight frame are not disturbed.
- oTX, oBusy and oByteIdx are registered outputs; no combinational path from any input to any output.
- Reset values: oTX=1, oBusy=0, oDone=0, oByteIdx=0, state=IDLE, timers 0, buffer 0.
- Reset asserted mid-frame: on that edge oTX is forced high and the FSM returns to IDLE. No oDone is issued. The next iStart after reset release sends a complete new frame.

## Timing
- iStart sampled high at edge E0 (IDLE): oTX=0 and oBusy=1 from E0. The start bit of byte 0 occupies edges E0..E0+CLK_DIV.
- Byte k start edge: E0 + k·(10+GAP_BITS)·CLK_DIV.
- Frame length: L = (140 + 13·GAP_BITS)·CLK_DIV cycles.
- At edge E0+L: oBusy=0, oDone=1 for one cycle, oByteIdx=0, oTX stays 1.
- An iStart sampled in the oDone cycle is accepted. Back-to-back frames are legal with zero idle gap beyond the last stop bit.
- oByteIdx updates on the same edge that oTX enters the START bit of the new byte.

## Test plan
- Reset values, CLK_DIV=4: release reset, hold 20 cycles -> oTX=1, oBusy=0, oDone=0, oByteIdx=0 throughout.
- Single frame, CLK_DIV=4, GAP_BITS=0, iMARK=0xCC, im1b1=0x81, all other bytes 0x32, iCRC8=0xBE -> sampling mid-bit gives:
  - byte 0: 0,0,0,1,1,0,0,1,1,1 (0xCC LSB first);
  - byte 1: 0,1,0,0,0,0,0,0,1,1;
  - last byte: 0,0,1,1,1,1,1,0,1,1;
  - oDone exactly 560 cycles after the iStart edge.
- Busy start rejection: second iStart with iMARK=0x55 at cycle 100 of a frame -> the transmitted frame is unchanged, oDone fires once at cycle 560.
- Gap insertion, GAP_BITS=2, CLK_DIV=4: 8 idle-high cycles between each stop bit and the next start bit, none after byte 13, oDone at cycle 664.
- Back-to-back frames: iStart in the oDone cycle -> oTX falls on that edge, oBusy low for exactly one cycle, second frame bit-exact.
- Mid-frame reset: assert reset during byte 5 -> oTX=1 and oBusy=0 asynchronously, no oDone. A new iStart after release sends byte 0 first, full length.

Source files
------------

// File: rtl/frame_uart_tx.sv
// Purpose : serialises a latched 14-byte response frame (MARK, m1b1..m3b4, CRC8) as 8N1 UART, LSB first.
// Latency : the start bit of byte 0 appears on the edge that samples iStart; frame = (140+13*GAP_BITS)*CLK_DIV cycles.
// Backpr. : none; iStart while busy is ignored, and back-to-back frames are accepted from the oDone cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   iStart                 - one-cycle strobe, latches frame bytes when idle
//   iMARK .. iCRC8         - 14 frame bytes in transmit order
//   oTX                    - serial line, idle high (registered)
//   oBusy                  - frame in progress (registered)
//   oDone                  - one-cycle pulse when the final stop bit completes
//   oByteIdx               - index of the byte on the line, 0 when idle
module frame_uart_tx #(
    parameter int CLK_DIV  = 16,
    parameter int GAP_BITS = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic [7:0] iMARK,
    input  logic [7:0] im1b1,
    input  logic [7:0] im1b2,
    input  logic [7:0] im1b3,
    input  logic [7:0] im1b4,
    input  logic [7:0] im2b1,
    input  logic [7:0] im2b2,
    input  logic [7:0] im2b3,
    input  logic [7:0] im2b4,
    input  logic [7:0] im3b1,
    input  logic [7:0] im3b2,
    input  logic [7:0] im3b3,
    input  logic [7:0] im3b4,
    input  logic [7:0] iCRC8,
    output logic       oTX,
    output logic       oBusy,
    output logic       oDone,
    output logic [3:0] oByteIdx
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    // Only meaningful when GAP_BITS > 0; the GAP state is unreachable otherwise.
    localparam logic [3:0]  GAP_LAST = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
    localparam logic [3:0]  IDX_LAST = 4'd13;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [2:0]  r_bit,   w_bit_nxt;
    logic [3:0]  r_gap,   w_gap_nxt;
    logic [3:0]  r_idx,   w_idx_nxt;
    logic        r_tx,    w_tx_nxt;
    logic        r_busy,  w_busy_nxt;
    logic        r_done,  w_done_nxt;
    logic        w_load;
    logic        w_tick;
    logic [2:0]  w_bit_inc;
    logic [7:0]  w_cur;
    logic [7:0]  w_in  [14];
    logic [7:0]  r_buf [14];

    always_comb begin
        w_in = '{iMARK, im1b1, im1b2, im1b3, im1b4, im2b1, im2b2, im2b3, im2b4,
                 im3b1, im3b2, im3b3, im3b4, iCRC8};
    end

    assign w_tick    = (r_timer == DIV_LAST);
    assign w_bit_inc = r_bit + 3'd1;
    assign w_cur     = r_buf[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_tick ? 16'd0 : r_timer + 16'd1;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Timer parked at 0 so the first start bit is a full bit time.
                w_timer_nxt = 16'd0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                if (iStart) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_idx_nxt   = 4'd0;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = w_cur[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = w_cur[w_bit_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 4'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = S_START;
                        w_idx_nxt   = r_idx + 4'd1;
                        w_tx_nxt    = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_gap == GAP_LAST) begin
                        w_state_nxt = S_START;
                        w_idx_nxt   = r_idx + 4'd1;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_gap_nxt = r_gap + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= 16'd0;
            r_bit   <= 3'd0;
            r_gap   <= 4'd0;
            r_idx   <= 4'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 14; i++) r_buf[i] <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_load) r_buf <= w_in;
        end
    end

    assign oTX      = r_tx;
    assign oBusy    = r_busy;
    assign oDone    = r_done;
    assign oByteIdx = r_idx;

endmodule
